// File: rtl/usb_rx_pkg.sv
`default_nettype none
// ============================================================================
// usb_rx_pkg : shared types, PID constants and helpers for the USB RX sequencer
// Revision   : 1.0
// ============================================================================
package usb_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_PID  = 3'd1,
        ST_TOKEN    = 3'd2,
        ST_DATA     = 3'd3,
        ST_HSHAKE   = 3'd4,
        ST_ERR_WAIT = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_IN    = 3'd1,
        PKT_OUT   = 3'd2,
        PKT_DATA0 = 3'd3,
        PKT_DATA1 = 3'd4,
        PKT_ACK   = 3'd5,
        PKT_NAK   = 3'd6,
        PKT_ERROR = 3'd7
    } pkt_e;

    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    // The upper nibble must be the bitwise complement of the lower one.
    function automatic logic pid_valid(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_rx_crc_holdoff.sv
`default_nettype none
// ============================================================================
// usb_rx_crc_holdoff : 2-deep byte pipeline that keeps the trailing CRC16 out
//                      of the RX buffer by releasing bytes two positions late
// Revision           : 1.0
// ============================================================================
module usb_rx_crc_holdoff (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       shift_i,
    input  logic [7:0] byte_i,
    output logic       store_o,
    output logic [7:0] data_o
);

    logic [7:0] hold0_q;
    logic [7:0] hold1_q;
    logic [1:0] fill_q;
    logic       store_q;
    logic [7:0] data_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            hold0_q <= '0;
            hold1_q <= '0;
            fill_q  <= '0;
            store_q <= 1'b0;
            data_q  <= '0;
        end else begin
            store_q <= 1'b0;
            if (shift_i) begin
                hold0_q <= byte_i;
                hold1_q <= hold0_q;
                if (fill_q == 2'd2) begin
                    store_q <= 1'b1;
                    data_q  <= hold1_q;
                end else begin
                    fill_q <= fill_q + 2'd1;
                end
            end
        end
    end

    assign store_o = store_q;
    assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/usb_rx_packet_sequencer.sv
`default_nettype none
// ============================================================================
// usb_rx_packet_sequencer : byte-level USB RX framing, PID classification,
//                           payload storage and end-of-packet verdict
// Revision                : 1.0
// ============================================================================
module usb_rx_packet_sequencer
    import usb_rx_pkg::*;
#(
    parameter int          MAX_DATA_BYTES = 64,
    parameter logic [7:0]  SYNC_BYTE      = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       byte_valid,
    input  logic       eop,
    input  logic       rx_error,
    input  logic       crc_ok,
    output logic       clear_crc,
    output logic       store_rx_packet_data,
    output logic [7:0] rx_packet_data,
    output logic [2:0] rx_packet,
    output logic       rx_done,
    output logic       rx_busy
);

    state_e     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    pkt_e       pid_q, pid_d;
    pkt_e       code_q, code_d;
    logic       clear_crc_q, clear_crc_d;
    pkt_e       rx_packet_q, rx_packet_d;
    logic       rx_done_q, rx_done_d;

    logic       w_sync;
    logic       w_shift;
    state_e     w_pid_state;
    pkt_e       w_pid_code;
    pkt_e       w_eop_code;

    assign w_sync  = (state_q == ST_IDLE) && byte_valid && (rx_byte == SYNC_BYTE);
    assign w_shift = (state_q == ST_DATA) && byte_valid && !rx_error && !eop;

    always_comb begin
        w_pid_state = ST_ERR_WAIT;
        w_pid_code  = PKT_ERROR;
        if (pid_valid(rx_byte)) begin
            case (rx_byte[3:0])
                PID_IN:    begin w_pid_state = ST_TOKEN;  w_pid_code = PKT_IN;    end
                PID_OUT:   begin w_pid_state = ST_TOKEN;  w_pid_code = PKT_OUT;   end
                PID_DATA0: begin w_pid_state = ST_DATA;   w_pid_code = PKT_DATA0; end
                PID_DATA1: begin w_pid_state = ST_DATA;   w_pid_code = PKT_DATA1; end
                PID_ACK:   begin w_pid_state = ST_HSHAKE; w_pid_code = PKT_ACK;   end
                PID_NAK:   begin w_pid_state = ST_HSHAKE; w_pid_code = PKT_NAK;   end
                default:   begin w_pid_state = ST_ERR_WAIT; w_pid_code = PKT_ERROR; end
            endcase
        end
    end

    // cnt_q includes the two CRC16 bytes for DATA and the CRC5 word for tokens.
    always_comb begin
        w_eop_code = PKT_ERROR;
        case (state_q)
            ST_TOKEN:  if (cnt_q == 7'd2 && crc_ok) w_eop_code = pid_q;
            ST_HSHAKE: if (cnt_q == 7'd0) w_eop_code = pid_q;
            ST_DATA:   if (cnt_q >= 7'd2 && (int'(cnt_q) - 2) <= MAX_DATA_BYTES && crc_ok)
                           w_eop_code = pid_q;
            default:   w_eop_code = PKT_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pid_q       <= PKT_NONE;
            code_q      <= PKT_NONE;
            clear_crc_q <= 1'b0;
            rx_packet_q <= PKT_NONE;
            rx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pid_q       <= pid_d;
            code_q      <= code_d;
            clear_crc_q <= clear_crc_d;
            rx_packet_q <= rx_packet_d;
            rx_done_q   <= rx_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pid_d   = pid_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (w_sync) begin
                    state_d = ST_GET_PID;
                    cnt_d   = '0;
                    pid_d   = PKT_NONE;
                    code_d  = PKT_NONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                // eop coinciding with a byte or a line error cannot be trusted.
                if (eop) begin
                    state_d = ST_DONE;
                    code_d  = (byte_valid || rx_error) ? PKT_ERROR : w_eop_code;
                end else if (rx_error) begin
                    state_d = ST_ERR_WAIT;
                end else if (byte_valid) begin
                    if (state_q == ST_GET_PID) begin
                        state_d = w_pid_state;
                        pid_d   = w_pid_code;
                    end else if (state_q != ST_ERR_WAIT && cnt_q != 7'h7F) begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        clear_crc_d = w_sync;
        rx_done_d   = (state_q == ST_DONE);
        if (w_sync)
            rx_packet_d = PKT_NONE;
        else if (state_q == ST_DONE)
            rx_packet_d = code_q;
        else
            rx_packet_d = rx_packet_q;
    end

    usb_rx_crc_holdoff u_holdoff (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_crc_q),
        .shift_i (w_shift),
        .byte_i  (rx_byte),
        .store_o (store_rx_packet_data),
        .data_o  (rx_packet_data)
    );

    assign clear_crc = clear_crc_q;
    assign rx_packet = rx_packet_q;
    assign rx_done   = rx_done_q;
    assign rx_busy   = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_packet_sequencer.sv
`default_nettype none
// ============================================================================
// tb_usb_rx_packet_sequencer : randomized and directed packets against a
//                              packet-level reference model
// Revision                   : 1.0
// ============================================================================
module tb_usb_rx_packet_sequencer;

    localparam int MAXB = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       byte_valid, eop, rx_error, crc_ok;
    logic       clear_crc, store_rx_packet_data, rx_done, rx_busy;
    logic [7:0] rx_packet_data;
    logic [2:0] rx_packet;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sq[$];
    int         clr_cnt  = 0;
    int         done_cnt = 0;
    int         got_code = 0;
    logic [7:0] pl[$];

    always #5 clk = ~clk;

    usb_rx_packet_sequencer #(.MAX_DATA_BYTES(MAXB), .SYNC_BYTE(8'h80)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rx_byte              (rx_byte),
        .byte_valid           (byte_valid),
        .eop                  (eop),
        .rx_error             (rx_error),
        .crc_ok               (crc_ok),
        .clear_crc            (clear_crc),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .rx_packet            (rx_packet),
        .rx_done              (rx_done),
        .rx_busy              (rx_busy)
    );

    always @(posedge clk) begin
        #1;
        if (store_rx_packet_data) sq.push_back(rx_packet_data);
        if (clear_crc) clr_cnt++;
        if (rx_done) begin
            done_cnt++;
            got_code = int'(rx_packet);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives one full clock cycle, starting and ending on a falling edge.
    task automatic cyc(input logic bv, input logic [7:0] b, input logic e,
                       input logic er, input logic c);
        byte_valid = bv;
        rx_byte    = b;
        eop        = e;
        rx_error   = er;
        crc_ok     = c;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'($urandom));
    endtask

    function automatic logic [7:0] garbage();
        logic [7:0] g;
        g = 8'($urandom);
        if (g == 8'h80) g = 8'h81;
        return g;
    endfunction

    function automatic int kind_of(input logic [7:0] p);
        case (p)
            8'h69:   return 1;
            8'hE1:   return 2;
            8'hC3:   return 3;
            8'h4B:   return 4;
            8'hD2:   return 5;
            8'h5A:   return 6;
            default: return 7;
        endcase
    endfunction

    function automatic int max0(input int v);
        return (v > 0) ? v : 0;
    endfunction

    // Sends SYNC, pid, the bytes in pl, then eop; err_idx >= 0 inserts an
    // rx_error pulse before payload byte err_idx; coll puts eop on the last byte.
    task automatic run_pkt(input string name, input logic [7:0] pid,
                           input int err_idx, input bit coll, input bit crc);
        int  n, k, exp_code, exp_st, base_sq, base_clr, base_done, got_st;
        bit  is_data;
        n        = pl.size();
        k        = kind_of(pid);
        is_data  = (k == 3 || k == 4);
        if (k == 7) begin
            exp_code = 7; exp_st = 0;
        end else if (err_idx >= 0) begin
            exp_code = 7; exp_st = is_data ? max0(err_idx - 2) : 0;
        end else if (coll) begin
            exp_code = 7; exp_st = is_data ? max0(n - 3) : 0;
        end else begin
            exp_st = is_data ? max0(n - 2) : 0;
            if (is_data)
                exp_code = (n >= 2 && n - 2 <= MAXB && crc) ? k : 7;
            else if (k <= 2)
                exp_code = (n == 2 && crc) ? k : 7;
            else
                exp_code = (n == 0) ? k : 7;
        end

        for (int g = 0; g < int'($urandom_range(0, 2)); g++)
            cyc(1'b1, garbage(), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        idle();
        base_sq   = sq.size();
        base_clr  = clr_cnt;
        base_done = done_cnt;

        cyc(1'b1, 8'h80, 1'b0, 1'b0, 1'($urandom));
        chk({name, ":pkt_clear"}, int'(rx_packet), 0);
        cyc(1'b1, pid, 1'b0, 1'b0, 1'($urandom));
        chk({name, ":busy"}, int'(rx_busy), 1);
        for (int i = 0; i < n; i++) begin
            if (i == err_idx) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
            if ($urandom_range(0, 3) == 0) idle();
            if (coll && i == n - 1)
                cyc(1'b1, pl[i], 1'b1, 1'b0, crc);
            else
                cyc(1'b1, pl[i], 1'b0, 1'b0, 1'($urandom));
        end
        if (err_idx == n) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        if (!coll) begin
            if ($urandom_range(0, 1) == 0) idle();
            cyc(1'b0, 8'h00, 1'b1, 1'b0, crc);
        end
        idle();
        for (int w = 0; w < 10 && done_cnt == base_done; w++) idle();
        if (done_cnt == base_done) chk({name, ":done_timeout"}, 0, 1);
        idle();
        idle();

        got_st = sq.size() - base_sq;
        chk({name, ":code"}, got_code, exp_code);
        chk({name, ":done_cnt"}, done_cnt - base_done, 1);
        chk({name, ":clear_cnt"}, clr_cnt - base_clr, 1);
        chk({name, ":stores"}, got_st, exp_st);
        for (int i = 0; i < exp_st && i < got_st; i++)
            chk({name, ":store_byte"}, int'(sq[base_sq + i]), int'(pl[i]));
        chk({name, ":idle_busy"}, int'(rx_busy), 0);
        cyc(1'b1, garbage(), 1'b0, 1'b0, 1'b0);
        idle();
        chk({name, ":hold"}, int'(rx_packet), exp_code);
    endtask

    task automatic fill(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endtask

    initial begin
        int base_done;
        logic [7:0] pids[8];
        rst = 1'b1;
        byte_valid = 1'b0; rx_byte = 8'h00; eop = 1'b0; rx_error = 1'b0; crc_ok = 1'b0;
        @(negedge clk);
        idle(); idle();
        chk("rst_clear_crc", int'(clear_crc), 0);
        chk("rst_store", int'(store_rx_packet_data), 0);
        chk("rst_data", int'(rx_packet_data), 0);
        chk("rst_packet", int'(rx_packet), 0);
        chk("rst_done", int'(rx_done), 0);
        chk("rst_busy", int'(rx_busy), 0);
        rst = 1'b0;
        idle();

        pl = '{8'h01, 8'h58};
        run_pkt("in_token", 8'h69, -1, 1'b0, 1'b1);
        pl = '{8'h11, 8'h22, 8'h33, 8'hAA, 8'hBB};
        run_pkt("data0", 8'hC3, -1, 1'b0, 1'b1);
        pl.delete();
        run_pkt("ack", 8'hD2, -1, 1'b0, 1'b1);
        pl = '{8'h00};
        run_pkt("ack_long", 8'hD2, -1, 1'b0, 1'b1);
        pl = '{8'h11};
        run_pkt("bad_pid", 8'hC4, -1, 1'b0, 1'b1);
        pl.delete();
        run_pkt("setup", 8'h2D, -1, 1'b0, 1'b1);
        pl = '{8'h80, 8'h80, 8'h12, 8'h34, 8'h56};
        run_pkt("data1_sync_payload", 8'h4B, -1, 1'b0, 1'b1);
        fill(8);
        run_pkt("data_rx_error", 8'hC3, 5, 1'b0, 1'b1);
        fill(64 + 2);
        run_pkt("data_max", 8'h4B, -1, 1'b0, 1'b1);
        fill(67 + 2);
        run_pkt("data_oversize", 8'hC3, -1, 1'b0, 1'b1);
        fill(6);
        run_pkt("data_coll", 8'hC3, -1, 1'b1, 1'b1);
        fill(4);
        run_pkt("data_crc_bad", 8'hC3, -1, 1'b0, 1'b0);
        fill(1);
        run_pkt("data_short", 8'h4B, -1, 1'b0, 1'b1);

        // Reset in the middle of a DATA packet aborts it silently.
        base_done = done_cnt;
        cyc(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(); idle();
        chk("midrst_busy", int'(rx_busy), 0);
        chk("midrst_store", int'(store_rx_packet_data), 0);
        chk("midrst_data", int'(rx_packet_data), 0);
        chk("midrst_packet", int'(rx_packet), 0);
        chk("midrst_clear", int'(clear_crc), 0);
        rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) idle();
        chk("midrst_no_done", done_cnt - base_done, 0);
        chk("midrst_idle", int'(rx_busy), 0);

        pids = '{8'h69, 8'hE1, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h2D, 8'hC4};
        for (int t = 0; t < 40; t++) begin
            logic [7:0] p;
            int k, n, e;
            bit col;
            p = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pids[$urandom_range(0, 7)];
            k = kind_of(p);
            if (k == 3 || k == 4)
                n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(64, 70)) : int'($urandom_range(0, 12));
            else if (k <= 2)
                n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : 2;
            else
                n = ($urandom_range(0, 3) == 0) ? 1 : 0;
            fill(n);
            e   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n)) : -1;
            col = (e < 0 && n > 0 && $urandom_range(0, 7) == 0);
            run_pkt("rand", p, e, col, ($urandom_range(0, 5) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
